// File: rtl/defines_pkg.sv
// Shared types and helpers for the stream buffer controller.
// Engine state enum plus the circular-pointer increment.
package defines_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } buff_state_e;

    function automatic logic [31:0] ptr_wrap(
        input logic [31:0] ptr,
        input logic [31:0] depth
    );
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_buff_ctrl_if.sv
// Producer/consumer-facing bundle of the stream buffer controller.
// The slave side is the buffer; the master side drives the toggles and data.
interface stream_buff_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
);
    localparam int LSIZE = $clog2(DEPTH);

    logic             wr_toggle;
    logic             rd_toggle;
    logic             err_clr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             wr_active;
    logic             rd_active;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [LSIZE:0]   level;
    logic             ovf;
    logic             udf;

    modport master (
        output wr_toggle, rd_toggle, err_clr, data_in,
        input  data_out, rd_valid, wr_active, rd_active,
        input  full, empty, almost_full, level, ovf, udf
    );

    modport slave (
        input  wr_toggle, rd_toggle, err_clr, data_in,
        output data_out, rd_valid, wr_active, rd_active,
        output full, empty, almost_full, level, ovf, udf
    );

endinterface

// File: rtl/buff_dpram.sv
// Storage for the stream buffer: one write port, one registered read port.
// The read register only loads when re is high, so it holds between reads.
module buff_dpram
    import defines_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/stream_buff_ctrl.sv
// Circular stream buffer with toggle-armed write/read engines and sticky errors.
// Define BDF_BUFF_OVERWRITE_EN to drop the oldest entry instead of blocking when full.
module stream_buff_ctrl
    import defines_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int DEPTH     = 64,
    parameter  int AF_THRESH = DEPTH - 8,
    localparam int LSIZE     = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    stream_buff_ctrl_if.slave bus
);

    buff_state_e      wr_st, wr_st_nx;
    buff_state_e      rd_st, rd_st_nx;
    logic [LSIZE-1:0] wr_ptr, rd_ptr;
    logic [LSIZE:0]   level;
    logic             wr_req, rd_req;
    logic             wr_fire, rd_fire, drop;
    logic             full, empty;
    logic             ovf_set, udf_set;
    logic             ovf_q, udf_q, rd_valid_q;
    logic [WIDTH-1:0] dout;

    assign full   = (level == (LSIZE+1)'(DEPTH));
    assign empty  = (level == '0);
    assign wr_req = (wr_st == ACTIVE);
    assign rd_req = (rd_st == ACTIVE);

    always_comb begin
        wr_st_nx = wr_st;
        rd_st_nx = rd_st;
        if (bus.wr_toggle) wr_st_nx = (wr_st == IDLE) ? ACTIVE : IDLE;
        if (bus.rd_toggle) rd_st_nx = (rd_st == IDLE) ? ACTIVE : IDLE;
    end

    always_comb begin
        rd_fire = rd_req & ~empty;
`ifdef BDF_BUFF_OVERWRITE_EN
        wr_fire = wr_req;
        drop    = wr_req & full & ~rd_fire;
`else
        wr_fire = wr_req & (~full | rd_fire);
        drop    = 1'b0;
`endif
        ovf_set = (wr_req & ~wr_fire) | drop;
        udf_set = rd_req & empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_st <= IDLE;
            rd_st <= IDLE;
        end else begin
            wr_st <= wr_st_nx;
            rd_st <= rd_st_nx;
        end
    end

    // A dropped entry moves rd_ptr without a read, keeping level at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (wr_fire)
                wr_ptr <= LSIZE'(ptr_wrap(32'(wr_ptr), 32'(DEPTH)));
            if (rd_fire | drop)
                rd_ptr <= LSIZE'(ptr_wrap(32'(rd_ptr), 32'(DEPTH)));
            if (wr_fire & ~rd_fire & ~full)
                level <= level + (LSIZE+1)'(1);
            else if (rd_fire & ~wr_fire)
                level <= level - (LSIZE+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set)          ovf_q <= 1'b1;
            else if (bus.err_clr) ovf_q <= 1'b0;
            if (udf_set)          udf_q <= 1'b1;
            else if (bus.err_clr) udf_q <= 1'b0;
        end
    end

    buff_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire & ~rst),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (rd_fire & ~rst),
        .raddr (rd_ptr),
        .rdata (dout)
    );

    assign bus.data_out    = dout;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.wr_active   = wr_req;
    assign bus.rd_active   = rd_req;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (level >= (LSIZE+1)'(AF_THRESH));
    assign bus.level       = level;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;

endmodule

// File: tb/tb_stream_buff_ctrl.sv
// Directed bench for stream_buff_ctrl: a DEPTH=5 vector table plus
// hand-written DEPTH=64 sequences for fill, drain, full r/w and reset.
module tb_stream_buff_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stream_buff_ctrl_if #(.WIDTH(16), .DEPTH(64)) bus64 ();
    stream_buff_ctrl_if #(.WIDTH(16), .DEPTH(5))  bus5 ();

    stream_buff_ctrl #(
        .WIDTH(16), .DEPTH(64), .AF_THRESH(56)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus64)
    );

    stream_buff_ctrl #(
        .WIDTH(16), .DEPTH(5), .AF_THRESH(4)
    ) dut5 (
        .clk(clk), .rst(rst), .bus(bus5)
    );

    typedef struct {
        logic        wt, rt, clr;
        logic [15:0] din;
        logic [3:0]  lvl;
        logic        full, empty, af, rv;
        logic [15:0] dout;
        logic        wa, ra, ovf, udf;
    } vec_t;

    vec_t tbl [18];
    int   errs   = 0;
    int   checks = 0;
    int   base;

    function automatic vec_t mk(
        input int wt, rt, clr, din,
        input int lvl, full, empty, af, rv, dout,
        input int wa, ra, ovf, udf
    );
        vec_t v;
        v.wt = 1'(wt);   v.rt = 1'(rt);   v.clr = 1'(clr);
        v.din = 16'(din); v.lvl = 4'(lvl);
        v.full = 1'(full); v.empty = 1'(empty);
        v.af = 1'(af);   v.rv = 1'(rv);   v.dout = 16'(dout);
        v.wa = 1'(wa);   v.ra = 1'(ra);
        v.ovf = 1'(ovf); v.udf = 1'(udf);
        return v;
    endfunction

    function automatic logic [27:0] s5();
        return {bus5.level, bus5.full, bus5.empty, bus5.almost_full,
                bus5.rd_valid, bus5.data_out, bus5.wr_active,
                bus5.rd_active, bus5.ovf, bus5.udf};
    endfunction

    function automatic logic [30:0] s64();
        return {bus64.level, bus64.full, bus64.empty, bus64.almost_full,
                bus64.rd_valid, bus64.data_out, bus64.wr_active,
                bus64.rd_active, bus64.ovf, bus64.udf};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1,0,0,0,      0,0,1,0,0,0,      1,0,0,0);
        tbl[1]  = mk(0,0,0,'hA001, 1,0,0,0,0,0,      1,0,0,0);
        tbl[2]  = mk(0,0,0,'hA002, 2,0,0,0,0,0,      1,0,0,0);
        tbl[3]  = mk(0,0,0,'hA003, 3,0,0,0,0,0,      1,0,0,0);
        tbl[4]  = mk(0,0,0,'hA004, 4,0,0,1,0,0,      1,0,0,0);
        tbl[5]  = mk(0,0,0,'hA005, 5,1,0,1,0,0,      1,0,0,0);
        tbl[6]  = mk(0,0,0,'hA006, 5,1,0,1,0,0,      1,0,1,0);
        tbl[7]  = mk(0,1,1,'hA006, 5,1,0,1,0,0,      1,1,1,0);
        tbl[8]  = mk(0,0,0,'hA006, 5,1,0,1,1,'hA001, 1,1,1,0);
        tbl[9]  = mk(1,0,1,'hA007, 5,1,0,1,1,'hA002, 0,1,0,0);
        tbl[10] = mk(0,0,0,0,      4,0,0,1,1,'hA003, 0,1,0,0);
        tbl[11] = mk(0,0,0,0,      3,0,0,0,1,'hA004, 0,1,0,0);
        tbl[12] = mk(0,0,0,0,      2,0,0,0,1,'hA005, 0,1,0,0);
        tbl[13] = mk(0,0,0,0,      1,0,0,0,1,'hA006, 0,1,0,0);
        tbl[14] = mk(0,0,0,0,      0,0,1,0,1,'hA007, 0,1,0,0);
        tbl[15] = mk(0,0,0,0,      0,0,1,0,0,'hA007, 0,1,0,1);
        tbl[16] = mk(0,1,0,0,      0,0,1,0,0,'hA007, 0,0,0,1);
        tbl[17] = mk(0,0,1,0,      0,0,1,0,0,'hA007, 0,0,0,0);

`ifdef BDF_BUFF_OVERWRITE_EN
        base = 1;
`else
        base = 0;
`endif
        rst = 1'b1;
        bus64.wr_toggle = 1'b0; bus64.rd_toggle = 1'b0;
        bus64.err_clr = 1'b0;   bus64.data_in = '0;
        bus5.wr_toggle = 1'b0;  bus5.rd_toggle = 1'b0;
        bus5.err_clr = 1'b0;    bus5.data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset64", s64(), {7'd0, 4'b0100, 16'h0, 4'b0000});
        chk("reset5", s5(), {4'd0, 4'b0100, 16'h0, 4'b0000});

`ifndef BDF_BUFF_OVERWRITE_EN
        for (int k = 0; k < 18; k++) begin
            bus5.wr_toggle = tbl[k].wt;
            bus5.rd_toggle = tbl[k].rt;
            bus5.err_clr   = tbl[k].clr;
            bus5.data_in   = tbl[k].din;
            tick();
            chk($sformatf("vec%0d", k), s5(),
                {tbl[k].lvl, tbl[k].full, tbl[k].empty, tbl[k].af,
                 tbl[k].rv, tbl[k].dout, tbl[k].wa, tbl[k].ra,
                 tbl[k].ovf, tbl[k].udf});
        end
        bus5.wr_toggle = 1'b0; bus5.rd_toggle = 1'b0;
        bus5.err_clr = 1'b0;
`endif

        // fill 64 words, then one blocked cycle
        bus64.wr_toggle = 1'b1;
        tick();
        bus64.wr_toggle = 1'b0;
        chk("wr_on", {bus64.wr_active, bus64.level}, {1'b1, 7'd0});
        for (int i = 0; i < 64; i++) begin
            bus64.data_in = 16'(i);
            tick();
            chk($sformatf("fill%0d", i),
                {bus64.level, bus64.almost_full, bus64.full},
                {7'(i + 1), 1'(i + 1 >= 56), 1'(i == 63)});
        end
        bus64.data_in = 16'h0040;
        bus64.wr_toggle = 1'b1;
        tick();
        bus64.wr_toggle = 1'b0;
        chk("ovf65", {bus64.ovf, bus64.level, bus64.wr_active},
            {1'b1, 7'd64, 1'b0});
        bus64.err_clr = 1'b1;
        tick();
        bus64.err_clr = 1'b0;
        chk("ovf_clr", bus64.ovf, 1'b0);

        // drain in order, then one underflowing cycle
        bus64.rd_toggle = 1'b1;
        tick();
        bus64.rd_toggle = 1'b0;
        chk("rd_on", {bus64.rd_active, bus64.rd_valid}, 2'b10);
        for (int i = 0; i < 64; i++) begin
            tick();
            chk($sformatf("drain%0d", i),
                {bus64.rd_valid, bus64.data_out, bus64.level},
                {1'b1, 16'(i + base), 7'(63 - i)});
        end
        chk("empty64", {bus64.empty, bus64.udf}, 2'b10);
        tick();
        chk("udf", {bus64.rd_valid, bus64.udf, bus64.data_out},
            {1'b0, 1'b1, 16'(63 + base)});
        bus64.rd_toggle = 1'b1;
        bus64.err_clr = 1'b1;
        tick();
        bus64.rd_toggle = 1'b0;
        bus64.err_clr = 1'b0;
        chk("udf_setwins", {bus64.rd_active, bus64.udf}, 2'b01);
        bus64.err_clr = 1'b1;
        tick();
        bus64.err_clr = 1'b0;
        chk("udf_clr", bus64.udf, 1'b0);

        // full buffer with simultaneous read and write
        bus64.wr_toggle = 1'b1;
        tick();
        bus64.wr_toggle = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus64.data_in = 16'(16'h0100 + i);
            bus64.rd_toggle = (i == 63);
            tick();
        end
        bus64.rd_toggle = 1'b0;
        chk("refill", {bus64.level, bus64.full, bus64.rd_active},
            {7'd64, 1'b1, 1'b1});
        bus64.data_in = 16'h5A5A;
        bus64.wr_toggle = 1'b1;
        tick();
        bus64.wr_toggle = 1'b0;
        chk("full_rw",
            {bus64.level, bus64.ovf, bus64.rd_valid, bus64.data_out,
             bus64.wr_active},
            {7'd64, 1'b0, 1'b1, 16'h0100, 1'b0});
        for (int j = 1; j <= 64; j++) begin
            bus64.rd_toggle = (j == 64);
            tick();
            chk($sformatf("rw_read%0d", j),
                {bus64.data_out, bus64.level},
                {(j < 64) ? 16'(16'h0100 + j) : 16'h5A5A, 7'(64 - j)});
        end
        bus64.rd_toggle = 1'b0;
        chk("rw_end", {bus64.empty, bus64.rd_active, bus64.udf}, 3'b100);

        // reset mid-stream with both engines active
        bus64.wr_toggle = 1'b1;
        tick();
        bus64.wr_toggle = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus64.data_in = 16'(16'h3000 + i);
            bus64.rd_toggle = (i == 29);
            tick();
        end
        bus64.rd_toggle = 1'b0;
        chk("lvl30", {bus64.level, bus64.wr_active, bus64.rd_active},
            {7'd30, 2'b11});
        tick();
        chk("stream30", {bus64.level, bus64.rd_valid, bus64.data_out},
            {7'd30, 1'b1, 16'h3000});
        rst = 1'b1;
        bus64.wr_toggle = 1'b1;
        bus64.rd_toggle = 1'b1;
        tick();
        rst = 1'b0;
        bus64.wr_toggle = 1'b0;
        bus64.rd_toggle = 1'b0;
        chk("mid_reset", s64(), {7'd0, 4'b0100, 16'h0, 4'b0000});
        tick();
        chk("post_reset", {bus64.wr_active, bus64.rd_active, bus64.level},
            {2'b00, 7'd0});

`ifdef BDF_BUFF_OVERWRITE_EN
        bus64.wr_toggle = 1'b1;
        tick();
        bus64.wr_toggle = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            bus64.data_in = 16'(i);
            bus64.wr_toggle = (i == 70);
            tick();
        end
        bus64.wr_toggle = 1'b0;
        chk("ow_full", {bus64.level, bus64.ovf, bus64.wr_active},
            {7'd64, 1'b1, 1'b0});
        bus64.rd_toggle = 1'b1;
        tick();
        bus64.rd_toggle = 1'b0;
        for (int j = 0; j < 64; j++) begin
            bus64.rd_toggle = (j == 63);
            tick();
            chk($sformatf("ow_read%0d", j), bus64.data_out, 16'(7 + j));
        end
        bus64.rd_toggle = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
